// File: rtl/op_checker_pkg.sv
// Shared types and constants for the operator result checker.
// Contents: run state encoding, result counter width and saturation limit,
// and a saturating increment helper for the pass/fail counters.
package op_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    // Counters stick at CNT_MAX instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/op_checker_timer.sv
// Per-result watchdog: counts enabled cycles and flags expiry at TIMEOUT_CYCLES.
// Latency: expired is a registered-count compare, valid in the same cycle as the count.
// Ports: clk/reset (sync, active-high), clr (highest priority), en (count), expired (out).
module op_checker_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign expired = (cnt_q == TW'(TIMEOUT_CYCLES));

    // Count stops once expired so it can never wrap past the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/op_result_checker.sv
// Checks a fixed-length stream of results against a harness table; one verdict per run.
// Latency: counts/check_idx update the cycle after each handshake; done the cycle after the last.
// Backpressure: res_ready high only in WAIT, one accept per cycle; per-result timeout ends the run.
// Ports: start, res_valid/res_data/res_ready, exp_data (indexed by check_idx),
// pass_count, fail_count, done, passed, timed_out.
// Optional OP_CHECKER_FIRST_FAIL_EN adds first_fail_idx / first_fail_data.
module op_result_checker
    import op_checker_pkg::*;
#(
    parameter  int DATA_W         = 32,
    parameter  int NUM_CHECKS     = 4,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    input  logic [DATA_W-1:0] exp_data,
    output logic [IDX_W-1:0]  check_idx,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              done,
    output logic              passed,
    output logic              timed_out
`ifdef OP_CHECKER_FIRST_FAIL_EN
    ,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_data
`endif
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  check_idx_q, check_idx_d;
    logic [CNT_W-1:0]  pass_count_q, pass_count_d;
    logic [CNT_W-1:0]  fail_count_q, fail_count_d;
    logic              timed_out_q, timed_out_d;
`ifdef OP_CHECKER_FIRST_FAIL_EN
    logic [IDX_W-1:0]  first_fail_idx_q, first_fail_idx_d;
    logic [DATA_W-1:0] first_fail_data_q, first_fail_data_d;
`endif

    logic hs;
    logic restart;
    logic last;
    logic expired;

    // res_ready is exactly "in WAIT", so the handshake needs only res_valid here.
    assign hs      = (state_q == WAIT) && res_valid;
    // start is honoured from IDLE and DONE; ignored mid-run.
    assign restart = (state_q != WAIT) && start;
    assign last    = (check_idx_q == IDX_W'(NUM_CHECKS - 1));

    // Timer restarts on every accepted result so the limit is per result.
    op_checker_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (restart || hs),
        .en      (state_q == WAIT),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a handshake in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WAIT;
            WAIT: begin
                if (hs) begin
                    if (last) state_d = DONE;
                end else if (expired) begin
                    state_d = DONE;
                end
            end
            DONE:    if (start) state_d = WAIT;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        res_ready  = (state_q == WAIT);
        done       = (state_q == DONE);
        passed     = (state_q == DONE) && (fail_count_q == '0) && !timed_out_q;
        check_idx  = check_idx_q;
        pass_count = pass_count_q;
        fail_count = fail_count_q;
        timed_out  = timed_out_q;
    end

`ifdef OP_CHECKER_FIRST_FAIL_EN
    assign first_fail_idx  = first_fail_idx_q;
    assign first_fail_data = first_fail_data_q;
`endif

    // Run bookkeeping: counters, index and verdict flags.
    always_comb begin
        check_idx_d  = check_idx_q;
        pass_count_d = pass_count_q;
        fail_count_d = fail_count_q;
        timed_out_d  = timed_out_q;
`ifdef OP_CHECKER_FIRST_FAIL_EN
        first_fail_idx_d  = first_fail_idx_q;
        first_fail_data_d = first_fail_data_q;
`endif
        if (restart) begin
            check_idx_d  = '0;
            pass_count_d = '0;
            fail_count_d = '0;
            timed_out_d  = 1'b0;
`ifdef OP_CHECKER_FIRST_FAIL_EN
            first_fail_idx_d  = '0;
            first_fail_data_d = '0;
`endif
        end else if (hs) begin
            if (res_data == exp_data) begin
                pass_count_d = sat_inc(pass_count_q);
            end else begin
                fail_count_d = sat_inc(fail_count_q);
`ifdef OP_CHECKER_FIRST_FAIL_EN
                // A zero fail count means this mismatch is the first of the run.
                if (fail_count_q == '0) begin
                    first_fail_idx_d  = check_idx_q;
                    first_fail_data_d = res_data;
                end
`endif
            end
            // Index parks on the final entry once the run completes.
            if (!last) begin
                check_idx_d = check_idx_q + 1'b1;
            end
        end else if ((state_q == WAIT) && expired) begin
            timed_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            check_idx_q  <= '0;
            pass_count_q <= '0;
            fail_count_q <= '0;
            timed_out_q  <= 1'b0;
`ifdef OP_CHECKER_FIRST_FAIL_EN
            first_fail_idx_q  <= '0;
            first_fail_data_q <= '0;
`endif
        end else begin
            check_idx_q  <= check_idx_d;
            pass_count_q <= pass_count_d;
            fail_count_q <= fail_count_d;
            timed_out_q  <= timed_out_d;
`ifdef OP_CHECKER_FIRST_FAIL_EN
            first_fail_idx_q  <= first_fail_idx_d;
            first_fail_data_q <= first_fail_data_d;
`endif
        end
    end

endmodule

// File: doc/op_result_checker.md
# op_result_checker

Downstream consumer for generated operator test FSMs. It accepts a fixed-length sequence of 32-bit results over a valid/ready handshake and compares each against an expected value indexed by the checker. It counts passes and failures, enforces a per-result timeout, and reports a single pass/fail verdict for the simulation harness to act on.

## Interface
Parameters:
- DATA_W, 32, result and expected word width
- NUM_CHECKS, 4, results expected per run (≥1)
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT without a handshake (≥1)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle run request
- res_valid  in  1  upstream result valid
- res_data  in  DATA_W  upstream result word
- res_ready  out  1  checker accepts result this cycle
- exp_data  in  DATA_W  expected word for current check_idx, combinational from harness table
- check_idx  out  $clog2(NUM_CHECKS) (min 1)  index of result awaited
- pass_count  out  8  matches this run
- fail_count  out  8  mismatches this run
- done  out  1  run finished (level)
- passed  out  1  valid when done: all matched, no timeout
- timed_out  out  1  valid when done: run ended by timeout

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: res_ready=0. On start → WAIT; clear counters, check_idx, timer.
- WAIT: res_ready=1. Handshake = res_valid && res_ready. On handshake compare res_data == exp_data (full DATA_W, unsigned equality); increment pass_count or fail_count; clear timer; if check_idx == NUM_CHECKS-1 → DONE, else check_idx+1.
- Timer increments each WAIT cycle without a handshake; at TIMEOUT_CYCLES → DONE with timed_out=1.
- DONE: res_ready=0, done=1, passed = (fail_count==0 && !timed_out). start in DONE restarts as from IDLE. Outputs hold until reset or restart.
- Counters saturate at 255 (no wrap).
- start while in WAIT is ignored.
- res_valid outside WAIT: ignored, no count change.

## Timing
- Reset values: res_ready=0, check_idx=0, pass_count=0, fail_count=0, done=0, passed=0, timed_out=0, state IDLE, timer 0.
- reset asserted in any state: all of the above on the next edge, in-flight result discarded.
- start at edge N → WAIT and res_ready=1 from cycle N+1.
- Handshake at edge M → counts and check_idx updated in M+1. Final handshake → done=1 in M+1. Back-to-back accepts supported, one per cycle.
- Timeout: with no handshake, done=1 and timed_out=1 exactly TIMEOUT_CYCLES+1 cycles after entering WAIT (timer restarts after every handshake).
- A handshake in the same cycle the timer would expire wins: the result is counted and the timer is cleared.
- exp_data is sampled in the handshake cycle only.

## Configuration
- OP_CHECKER_FIRST_FAIL_EN defined: adds outputs first_fail_idx (check_idx width) and first_fail_data (DATA_W). These capture the index and res_data of the first mismatch in a run. Both are cleared on reset and start, and hold thereafter.
- Undefined: both ports and their registers are absent; all other behaviour is identical.

## Structure
- Package op_checker_pkg: state typedef enum {IDLE, WAIT, DONE}; constants CNT_W=8, CNT_MAX=255.
- Sub-module op_checker_timer: clear/enable/expire counter parameterised by TIMEOUT_CYCLES.

## Test plan
- Reset, start, then four results 0,1,2,3 with exp_data matching, valid every cycle → pass_count=4, fail_count=0, done=1, passed=1, done 1 cycle after 4th handshake.
- Same run with 2nd result 32'hDEADBEEF vs expected 1 → fail_count=1, pass_count=3, passed=0. With macro: first_fail_idx=1, first_fail_data=DEADBEEF.
- start, never assert res_valid → done=1, timed_out=1, passed=0 exactly 17 cycles after WAIT entry (TIMEOUT_CYCLES=16).
- Valid arrives on cycle 16 of waiting → accepted, no timeout. Valid gaps of 15 cycles between results → run passes.
- Assert reset after 2 handshakes → all outputs 0 next cycle. A new start runs cleanly from check_idx=0.
- In DONE, pulse start → counters cleared, res_ready=1 next cycle. res_valid pulses in IDLE → counts stay 0.
